// File: rtl/snoop_dispatcher.sv
// Hands the single snooper to one of N packet-filter cores at a time, round-robin,
// and forwards its writes and done handshake to the granted core only.
module snoop_dispatcher #(
   parameter int N_CORES           = 4,
   parameter int SN_FWD_DATA_WIDTH = 64,
   parameter int SN_FWD_ADDR_WIDTH = 9,
   parameter int INC_WIDTH         = 8,
   localparam int SEL_WIDTH        = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [SN_FWD_ADDR_WIDTH-1:0] sn_addr,
   input  logic [SN_FWD_DATA_WIDTH-1:0] sn_wr_data,
   input  logic                         sn_wr_en,
   input  logic [INC_WIDTH-1:0]         sn_byte_inc,
   input  logic                         sn_done,
   output logic                         sn_done_ack,
   output logic                         rdy_for_sn,
   input  logic                         rdy_for_sn_ack,
   output logic [SN_FWD_ADDR_WIDTH-1:0] core_addr,
   output logic [SN_FWD_DATA_WIDTH-1:0] core_wr_data,
   output logic [INC_WIDTH-1:0]         core_byte_inc,
   output logic [N_CORES-1:0]           core_wr_en,
   output logic [N_CORES-1:0]           core_done,
   input  logic [N_CORES-1:0]           core_done_ack,
   input  logic [N_CORES-1:0]           core_rdy_for_sn,
   output logic [N_CORES-1:0]           core_rdy_for_sn_ack,
   output logic [SEL_WIDTH-1:0]         cur_sel,
   output logic                         busy,
   output logic [15:0]                  drop_cnt,
   output logic [1:0]                   dbg_state
);

   // Handshakes: every level/pulse is sampled on the rising edge; a pulse is
   // high for exactly one cycle, a level is held until its ack is sampled.
   typedef enum logic [1:0] {IDLE, GRANT, ACTIVE, DONE_WAIT} state_t;

   state_t               state;
   logic [SEL_WIDTH-1:0] last_sel;
   logic [SEL_WIDTH-1:0] rr_sel;
   logic                 rr_found;
   logic [N_CORES-1:0]   sel_onehot;
   int                   cand;

   assign sel_onehot = N_CORES'(1) << cur_sel;
   assign dbg_state  = state;

   // First ready core strictly after last_sel, wrapping around.
   always_comb begin
      rr_sel   = '0;
      rr_found = 1'b0;
      cand     = 0;
      for (int i = 1; i <= N_CORES; i++) begin
         cand = (int'(last_sel) + i) % N_CORES;
         if (!rr_found && core_rdy_for_sn[SEL_WIDTH'(cand)]) begin
            rr_found = 1'b1;
            rr_sel   = SEL_WIDTH'(cand);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state               <= IDLE;
         last_sel            <= SEL_WIDTH'(N_CORES - 1);
         cur_sel             <= '0;
         rdy_for_sn          <= 1'b0;
         sn_done_ack         <= 1'b0;
         busy                <= 1'b0;
         core_wr_en          <= '0;
         core_done           <= '0;
         core_rdy_for_sn_ack <= '0;
         core_addr           <= '0;
         core_wr_data        <= '0;
         core_byte_inc       <= '0;
         drop_cnt            <= '0;
      end else begin
         core_addr           <= sn_addr;
         core_wr_data        <= sn_wr_data;
         core_byte_inc       <= sn_byte_inc;
         core_wr_en          <= (state == ACTIVE && sn_wr_en) ? sel_onehot : '0;
         core_rdy_for_sn_ack <= '0;
         sn_done_ack         <= 1'b0;

         if (sn_wr_en && state != ACTIVE && drop_cnt != 16'hFFFF)
            drop_cnt <= drop_cnt + 16'd1;

         case (state)
            IDLE: begin
               if (rr_found) begin
                  cur_sel    <= rr_sel;
                  state      <= GRANT;
                  rdy_for_sn <= 1'b1;
                  busy       <= 1'b1;
               end
            end
            GRANT: begin
               // A snooper ack beats a simultaneous withdrawal of ready.
               if (rdy_for_sn_ack) begin
                  state               <= ACTIVE;
                  rdy_for_sn          <= 1'b0;
                  core_rdy_for_sn_ack <= sel_onehot;
                  last_sel            <= cur_sel;
               end else if (!core_rdy_for_sn[cur_sel]) begin
                  state      <= IDLE;
                  rdy_for_sn <= 1'b0;
                  busy       <= 1'b0;
               end
            end
            ACTIVE: begin
               if (sn_done) begin
                  state     <= DONE_WAIT;
                  core_done <= sel_onehot;
               end
            end
            DONE_WAIT: begin
               if (core_done_ack[cur_sel]) begin
                  state       <= IDLE;
                  sn_done_ack <= 1'b1;
                  core_done   <= '0;
                  busy        <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_snoop_dispatcher.sv
// Randomized and directed bench for snoop_dispatcher: round-robin model, write
// scoreboard, drop counter model and done handshake timing.
module tb_snoop_dispatcher;

   logic        clk = 1'b0;
   logic        rst;
   logic [8:0]  sn_addr;
   logic [63:0] sn_wr_data;
   logic        sn_wr_en;
   logic [7:0]  sn_byte_inc;
   logic        sn_done;
   logic        sn_done_ack;
   logic        rdy_for_sn;
   logic        rdy_for_sn_ack;
   logic [8:0]  core_addr;
   logic [63:0] core_wr_data;
   logic [7:0]  core_byte_inc;
   logic [3:0]  core_wr_en;
   logic [3:0]  core_done;
   logic [3:0]  core_done_ack;
   logic [3:0]  core_rdy_for_sn;
   logic [3:0]  core_rdy_for_sn_ack;
   logic [1:0]  cur_sel;
   logic        busy;
   logic [15:0] drop_cnt;
   logic [1:0]  dbg_state;

   snoop_dispatcher dut (
      .clk(clk), .rst(rst),
      .sn_addr(sn_addr), .sn_wr_data(sn_wr_data), .sn_wr_en(sn_wr_en),
      .sn_byte_inc(sn_byte_inc), .sn_done(sn_done), .sn_done_ack(sn_done_ack),
      .rdy_for_sn(rdy_for_sn), .rdy_for_sn_ack(rdy_for_sn_ack),
      .core_addr(core_addr), .core_wr_data(core_wr_data), .core_byte_inc(core_byte_inc),
      .core_wr_en(core_wr_en), .core_done(core_done), .core_done_ack(core_done_ack),
      .core_rdy_for_sn(core_rdy_for_sn), .core_rdy_for_sn_ack(core_rdy_for_sn_ack),
      .cur_sel(cur_sel), .busy(busy), .drop_cnt(drop_cnt), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int m_last = 3;
   int exp_drop = 0;
   int ack_pulses = 0;
   logic [82:0] exp_q[$];
   logic [82:0] mon_e;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [3:0] oh(input int s);
      oh = 4'b0001 << s;
   endfunction

   // Reference arbitration: lowest index at or after last+1, wrapping.
   function automatic int rr_pick(input logic [3:0] mask);
      rr_pick = -1;
      for (int i = 1; i <= 4; i++)
         if (rr_pick < 0 && mask[(m_last + i) % 4]) rr_pick = (m_last + i) % 4;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic rand_data;
      sn_addr     = 9'($urandom);
      sn_wr_data  = {$urandom, $urandom};
      sn_byte_inc = 8'($urandom);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_rdy"}, rdy_for_sn, 0);
      chk({tag, "_dack"}, sn_done_ack, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_wren"}, core_wr_en, 0);
      chk({tag, "_cdone"}, core_done, 0);
      chk({tag, "_rack"}, core_rdy_for_sn_ack, 0);
      chk({tag, "_addr"}, core_addr, 0);
      chk({tag, "_data"}, core_wr_data, 0);
      chk({tag, "_inc"}, core_byte_inc, 0);
      chk({tag, "_drop"}, drop_cnt, 0);
      chk({tag, "_sel"}, cur_sel, 0);
   endtask

   task automatic idle_drop;
      rand_data();
      sn_wr_en = 1'b1;
      exp_drop++;
      tick();
      sn_wr_en = 1'b0;
   endtask

   task automatic do_grant(input logic [3:0] mask, input bit drop_in_grant, output int sel);
      sel = rr_pick(mask);
      core_rdy_for_sn = mask;
      tick();
      chk("grant_rdy", rdy_for_sn, 1);
      chk("grant_sel", cur_sel, sel);
      chk("grant_busy", busy, 1);
      if (drop_in_grant) begin
         rand_data();
         sn_wr_en = 1'b1;
         exp_drop++;
         tick();
         sn_wr_en = 1'b0;
      end
      rdy_for_sn_ack = 1'b1;
      tick();
      rdy_for_sn_ack  = 1'b0;
      core_rdy_for_sn = 4'b0;
      chk("ack_pulse", core_rdy_for_sn_ack, oh(sel));
      chk("grant_rdy_off", rdy_for_sn, 0);
      m_last = sel;
   endtask

   task automatic do_write(input int sel, input logic [8:0] a, input logic [63:0] d,
                           input logic [7:0] inc);
      logic [1:0] s2;
      s2 = 2'(sel);
      sn_addr = a; sn_wr_data = d; sn_byte_inc = inc;
      sn_wr_en = 1'b1;
      exp_q.push_back({s2, a, d, inc});
      tick();
      sn_wr_en = 1'b0;
   endtask

   task automatic finish_pkt(input int sel, input int delay, input bit wr_with_done);
      int hi;
      logic [1:0] s2;
      s2 = 2'(sel);
      sn_done = 1'b1;
      if (wr_with_done) begin
         rand_data();
         sn_wr_en = 1'b1;
         exp_q.push_back({s2, sn_addr, sn_wr_data, sn_byte_inc});
      end
      tick();
      sn_wr_en = 1'b0;
      hi = 0;
      for (int k = 1; k <= delay; k++) begin
         if (core_done == oh(sel)) hi++;
         if (k == 1) begin
            rand_data();
            sn_wr_en = 1'b1;
            exp_drop++;
         end
         core_done_ack = (k == delay) ? oh(sel) : (4'($urandom) & ~oh(sel));
         tick();
         sn_wr_en = 1'b0;
      end
      core_done_ack = 4'b0;
      chk("done_cycles", hi, delay);
      chk("sn_done_ack", sn_done_ack, 1);
      chk("done_clear", core_done, 0);
      chk("idle_busy", busy, 0);
      sn_done = 1'b0;
      tick();
      chk("sn_done_ack_once", sn_done_ack, 0);
   endtask

   // Scoreboard for the forwarded write path and one-hot invariants.
   always @(negedge clk) begin
      if (rst) begin
         if (core_rdy_for_sn_ack != 4'b0) ack_pulses++;
         if (core_wr_en != 4'b0) begin
            if (exp_q.size() == 0) begin
               chk("wr_unexpected", core_wr_en, 0);
            end else begin
               mon_e = exp_q.pop_front();
               chk("wr_en", core_wr_en, oh(int'(mon_e[82:81])));
               chk("wr_addr", core_addr, mon_e[80:72]);
               chk("wr_data", core_wr_data, mon_e[71:8]);
               chk("wr_inc", core_byte_inc, mon_e[7:0]);
            end
         end
         if (core_done != 4'b0) chk("done_onehot", $onehot0(core_done), 1);
         if (core_rdy_for_sn_ack != 4'b0) chk("rack_onehot", $onehot0(core_rdy_for_sn_ack), 1);
      end
   end

   initial begin
      int sel;
      int a0;
      int n;
      rst = 1'b0;
      sn_addr = '0; sn_wr_data = '0; sn_wr_en = 1'b0; sn_byte_inc = '0;
      sn_done = 1'b0; rdy_for_sn_ack = 1'b0; core_done_ack = '0; core_rdy_for_sn = '0;
      repeat (3) tick();
      check_all_zero("reset");
      rst = 1'b1;
      tick();

      // Drops in IDLE.
      repeat (3) idle_drop();
      tick();
      chk("drop3", drop_cnt, 3);

      // Round-robin from reset priority.
      for (int i = 0; i < 3; i++) begin
         do_grant(4'b1111, 1'b0, sel);
         chk("rr_cur_sel", cur_sel, i);
         do_write(sel, 9'($urandom), {$urandom, $urandom}, 8'($urandom));
         finish_pkt(sel, 2, 1'b0);
      end

      // Grant withdrawn before the snooper accepts.
      core_rdy_for_sn = 4'b0100;
      tick();
      chk("wd_grant_sel", cur_sel, 2);
      chk("wd_rdy", rdy_for_sn, 1);
      a0 = ack_pulses;
      core_rdy_for_sn = 4'b0000;
      tick();
      chk("wd_rdy_off", rdy_for_sn, 0);
      chk("wd_busy", busy, 0);
      tick();
      chk("wd_no_ack", ack_pulses, a0);
      do_grant(4'b1111, 1'b0, sel);
      chk("wd_last_kept", cur_sel, 3);

      // Late done ack on core 3.
      finish_pkt(sel, 5, 1'b0);

      // Write path on core 1.
      do_grant(4'b0010, 1'b0, sel);
      do_write(sel, 9'h005, 64'h0000_0000_DEAD_BEEF, 8'h10);
      chk("wp_en", core_wr_en, 4'b0010);
      chk("wp_addr", core_addr, 9'h005);
      chk("wp_data", core_wr_data, 64'hDEAD_BEEF);
      finish_pkt(sel, 1, 1'b0);
      chk("drop_mid", drop_cnt, 16'(exp_drop));

      // Reset in DONE_WAIT abandons the packet.
      do_grant(4'b1000, 1'b0, sel);
      sn_done = 1'b1;
      tick();
      chk("pre_rst_done", core_done, 4'b1000);
      #2;
      rst = 1'b0;
      #1;
      check_all_zero("midrst");
      sn_done = 1'b0;
      exp_q.delete();
      tick();
      rst = 1'b1;
      m_last = 3;
      exp_drop = 0;
      do_grant(4'b0110, 1'b0, sel);
      chk("post_rst_sel", cur_sel, 1);
      finish_pkt(sel, 3, 1'b1);

      // Randomized packets.
      for (int p = 0; p < 20; p++) begin
         do_grant(4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)), sel);
         n = $urandom_range(0, 4);
         for (int w = 0; w < n; w++) begin
            do_write(sel, 9'($urandom), {$urandom, $urandom}, 8'($urandom));
            if ($urandom_range(0, 2) == 0) tick();
         end
         finish_pkt(sel, $urandom_range(1, 6), 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 2)) idle_drop();
         chk("rand_drop", drop_cnt, 16'(exp_drop));
      end

      // Saturation of the drop counter.
      tick();
      n = 65534 - exp_drop;
      sn_wr_en = 1'b1;
      repeat (n) tick();
      chk("drop_fffe", drop_cnt, 16'hFFFE);
      tick();
      chk("drop_ffff", drop_cnt, 16'hFFFF);
      repeat (3) tick();
      chk("drop_sat", drop_cnt, 16'hFFFF);
      chk("drop_no_wr", core_wr_en, 0);
      sn_wr_en = 1'b0;
      tick();
      chk("queue_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/snoop_dispatcher.md
SNOOP_DISPATCHER -- requirements
Module: snoop_dispatcher

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- N_CORES, 4: number of packet-filter cores served.
- SN_FWD_DATA_WIDTH, 64: snoop write data width.
- SN_FWD_ADDR_WIDTH, 9: snoop write address width.
- INC_WIDTH, 8: byte-increment width.
- SEL_WIDTH, clog2(N_CORES) (derived, not set by user): core index width.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: single clock; all logic on the rising edge.
- rst, in, 1: asynchronous, active-low reset (asserted when 0).
- sn_addr, in, SN_FWD_ADDR_WIDTH: snooper write address.
- sn_wr_data, in, SN_FWD_DATA_WIDTH: snooper write data.
- sn_wr_en, in, 1: snooper write strobe.
- sn_byte_inc, in, INC_WIDTH: snooper byte increment.
- sn_done, in, 1: packet-done level, held by the snooper until sn_done_ack.
- sn_done_ack, out, 1: one-cycle acknowledge of sn_done.
- rdy_for_sn, out, 1: a core is granted and waiting for the snooper.
- rdy_for_sn_ack, in, 1: snooper accepts the grant (one-cycle pulse).
- core_addr, out, SN_FWD_ADDR_WIDTH: registered address, broadcast to all cores.
- core_wr_data, out, SN_FWD_DATA_WIDTH: registered data, broadcast.
- core_byte_inc, out, INC_WIDTH: registered byte increment, broadcast.
- core_wr_en, out, N_CORES: per-core write strobe, one-hot or zero.
- core_done, out, N_CORES: per-core done level.
- core_done_ack, in, N_CORES: per-core done acknowledge.
- core_rdy_for_sn, in, N_CORES: per-core ready level.
- core_rdy_for_sn_ack, out, N_CORES: per-core grant-accepted pulse.
- cur_sel, out, SEL_WIDTH: index of the currently granted core.
- busy, out, 1: high in any state other than IDLE.
- drop_cnt, out, 16: count of discarded snooper writes; saturates at 0xFFFF.

Function
REQ-003 The FSM SHALL have exactly four states: IDLE, GRANT, ACTIVE, DONE_WAIT.

REQ-004 In IDLE, if any core_rdy_for_sn bit is set, the block SHALL latch cur_sel by round-robin and enter GRANT on the next edge.
- Search starts at (last_sel+1) mod N_CORES and wraps.

REQ-005 rdy_for_sn SHALL be 1 exactly while the state is GRANT; it is registered.

REQ-006 In GRANT with rdy_for_sn_ack=1, the block SHALL enter ACTIVE, pulse core_rdy_for_sn_ack[cur_sel] for one cycle, and set last_sel=cur_sel.
- The pulse occurs in the same cycle as the GRANT->ACTIVE transition edge.

REQ-007 In GRANT, if core_rdy_for_sn[cur_sel]=0 and rdy_for_sn_ack=0, the block SHALL return to IDLE with no ack pulse and leave last_sel unchanged.
- If both occur in the same cycle, rdy_for_sn_ack wins and the block enters ACTIVE.

REQ-008 In ACTIVE, each cycle with sn_wr_en=1 SHALL, one cycle later, drive core_wr_en[cur_sel]=1 with core_addr, core_wr_data and core_byte_inc equal to the captured inputs.
- Fixed latency: 1 cycle.
- The data path registers SHALL capture every cycle regardless of state.

REQ-009 In IDLE, GRANT and DONE_WAIT, sn_wr_en=1 SHALL produce no core_wr_en and SHALL increment drop_cnt by 1, saturating at 0xFFFF.

REQ-010 In ACTIVE with sn_done=1, the block SHALL enter DONE_WAIT.
- core_done[cur_sel] SHALL be 1 from the cycle after entry until the ack cycle.
- A write and sn_done in the same cycle SHALL both be honoured: the write reaches the core before or with core_done.

REQ-011 In DONE_WAIT with core_done_ack[cur_sel]=1, the block SHALL pulse sn_done_ack for one cycle (registered), deassert core_done, and return to IDLE.
- core_done_ack bits of non-selected cores SHALL be ignored in all states.

REQ-012 At most one bit of core_wr_en, core_done and core_rdy_for_sn_ack SHALL be set in any cycle.

REQ-013 busy SHALL be 0 only in IDLE.

REQ-014 cur_sel SHALL hold its value from GRANT entry until the next IDLE->GRANT transition.

Reset
REQ-015 While rst=0, the block SHALL be in IDLE asynchronously, with these values:
- last_sel = N_CORES-1, so core 0 has first priority.
- cur_sel = 0.
- rdy_for_sn, sn_done_ack, busy = 0.
- core_wr_en, core_done, core_rdy_for_sn_ack = 0.
- core_addr, core_wr_data, core_byte_inc = 0.
- drop_cnt = 0.

REQ-016 Reset asserted mid-packet SHALL abandon the packet with no done or ack emitted; the first grant after release SHALL go to the lowest-index ready core.

Verification
REQ-017 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Round-robin: core_rdy_for_sn=4'b1111, three full packets -> grants in order 0,1,2; cur_sel=0,1,2.
- Grant withdrawn: core 2 drops ready in GRANT before the snooper ack -> IDLE, no core_rdy_for_sn_ack pulse, last_sel unchanged.
- Write path: ACTIVE on core 1, sn_wr_en with addr 0x05 and data 0xDEADBEEF -> next cycle core_wr_en=4'b0010, core_addr=0x05, core_wr_data=0xDEADBEEF.
- Drops: 3 writes in IDLE -> drop_cnt=3, core_wr_en=0; with preset 0xFFFF, one more drop -> drop_cnt stays 0xFFFF.
- Done: sn_done with core_done_ack[3] late by 5 cycles -> core_done[3] high for 5 cycles, then sn_done_ack pulses once and the block returns to IDLE.
- Reset: rst=0 in DONE_WAIT -> all outputs 0 immediately; after release, with core_rdy_for_sn=4'b0110, core 1 is granted.
